// File: rtl/alu_ctrl.sv
//==============================================================================
// Module  : alu_ctrl
// Brief   : Sequencer that loads ALU operands from a shared bus, runs one ALU
//           op, and optionally writes the result back into the accumulator.
// Revision: 1.0 - initial release
//==============================================================================
`default_nettype none

module alu_ctrl #(
  parameter int TIMEOUT = 15,
  parameter bit WB_EN   = 1'b1
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       START,
  input  logic [2:0] OPC,
  input  logic [7:0] BUS_in,
  input  logic       BUS_VALID,
  output logic [7:0] Acc_out,
  output logic [7:0] Breg_out,
  output logic [2:0] OP,
  output logic       ALU_OE,
  output logic       BUSY,
  output logic       DONE,
  output logic       ERR
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LD_A  = 3'd1,
    S_LD_B  = 3'd2,
    S_EXEC  = 3'd3,
    S_DRIVE = 3'd4,
    S_ABORT = 3'd5
  } state_t;

  localparam int               CNT_W     = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] C_TIMEOUT = TIMEOUT[CNT_W-1:0];
  localparam logic [CNT_W-1:0] C_ONE     = CNT_W'(1);

  state_t           state_q, state_d;
  logic [7:0]       acc_q,   acc_d;
  logic [7:0]       breg_q,  breg_d;
  logic [2:0]       op_q,    op_d;
  logic [CNT_W-1:0] wait_q,  wait_d;

  logic [CNT_W-1:0] wait_inc;
  logic             timeout_hit;
  logic             op_unary;

  assign wait_inc    = wait_q + C_ONE;
  assign timeout_hit = (TIMEOUT != 0) && !BUS_VALID && (wait_inc == C_TIMEOUT);
  assign op_unary    = (op_q == 3'b010) || (op_q == 3'b011) || (op_q == 3'b100);

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    breg_d  = breg_q;
    op_d    = op_q;
    wait_d  = wait_q;

    unique case (state_q)
      S_IDLE: begin
        if (START) begin
          op_d    = OPC;
          wait_d  = '0;
          state_d = S_LD_A;
        end
      end

      S_LD_A: begin
        if (BUS_VALID) begin
          acc_d   = BUS_in;
          wait_d  = '0;
          state_d = op_unary ? S_EXEC : S_LD_B;
        end else if (timeout_hit) begin
          wait_d  = '0;
          state_d = S_ABORT;
        end else if (TIMEOUT != 0) begin
          wait_d  = wait_inc;
        end
      end

      S_LD_B: begin
        if (BUS_VALID) begin
          breg_d  = BUS_in;
          wait_d  = '0;
          state_d = S_EXEC;
        end else if (timeout_hit) begin
          wait_d  = '0;
          state_d = S_ABORT;
        end else if (TIMEOUT != 0) begin
          wait_d  = wait_inc;
        end
      end

      // Operands and OP held steady; the external ALU registers its result here.
      S_EXEC: begin
        state_d = S_DRIVE;
      end

      // The ALU owns the bus this cycle, so BUS_in is the result.
      S_DRIVE: begin
        if (WB_EN) begin
          acc_d = BUS_in;
        end
        state_d = S_IDLE;
      end

      S_ABORT: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= S_IDLE;
      acc_q   <= 8'h00;
      breg_q  <= 8'h00;
      op_q    <= 3'b000;
      wait_q  <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      breg_q  <= breg_d;
      op_q    <= op_d;
      wait_q  <= wait_d;
    end
  end

  // State-decoded strobes fall with the asynchronous reset of state_q.
  assign ALU_OE   = (state_q == S_DRIVE);
  assign DONE     = (state_q == S_DRIVE);
  assign ERR      = (state_q == S_ABORT);
  assign BUSY     = (state_q != S_IDLE);
  assign Acc_out  = acc_q;
  assign Breg_out = breg_q;
  assign OP       = op_q;

endmodule

`default_nettype wire

// File: tb/tb_alu_ctrl.sv
//==============================================================================
// Module  : tb_alu_ctrl
// Brief   : Self-checking bench for alu_ctrl with a registered ALU bus model.
// Revision: 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_alu_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       start2 = 1'b0;
  logic [2:0] opc = 3'b000;
  logic       bus_valid = 1'b0;
  logic [7:0] opnd = 8'h00;

  logic [7:0] acc1, breg1, acc2, breg2, bus1, bus2, alu1_q, alu2_q;
  logic [2:0] op1, op2;
  logic       oe1, busy1, done1, err1, oe2, busy2, done2, err2;

  always #5 clk = ~clk;

  alu_ctrl dut (
    .CLK(clk), .RST(rst), .START(start), .OPC(opc), .BUS_in(bus1),
    .BUS_VALID(bus_valid), .Acc_out(acc1), .Breg_out(breg1), .OP(op1),
    .ALU_OE(oe1), .BUSY(busy1), .DONE(done1), .ERR(err1)
  );

  alu_ctrl #(.TIMEOUT(0), .WB_EN(1'b0)) dut_nwb (
    .CLK(clk), .RST(rst), .START(start2), .OPC(opc), .BUS_in(bus2),
    .BUS_VALID(bus_valid), .Acc_out(acc2), .Breg_out(breg2), .OP(op2),
    .ALU_OE(oe2), .BUSY(busy2), .DONE(done2), .ERR(err2)
  );

  function automatic logic [7:0] alu_f(input logic [2:0] op, input logic [7:0] a,
                                       input logic [7:0] b);
    case (op)
      3'b000:  return a + b;
      3'b001:  return a - b;
      3'b010:  return a - 8'h01;
      3'b011:  return a + 8'h01;
      3'b100:  return ~a;
      3'b101:  return a & b;
      3'b110:  return a | b;
      default: return a ^ b;
    endcase
  endfunction

  always @(posedge clk) begin
    alu1_q <= alu_f(op1, acc1, breg1);
    alu2_q <= alu_f(op2, acc2, breg2);
  end
  assign bus1 = oe1 ? alu1_q : opnd;
  assign bus2 = oe2 ? alu2_q : opnd;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [2:0] opc;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] res;
    int         lat;
  } vec_t;

  typedef struct {
    logic [2:0] op;
    logic [7:0] bus;
    logic [7:0] acc;
    logic [7:0] breg;
  } exp_t;

  exp_t       sb_q[$];
  logic [7:0] breg_m = 8'h00;

  // Scoreboard monitor: checks the DRIVE cycle, then the write-back one cycle later.
  initial begin
    exp_t       cur;
    logic       acc_pend = 1'b0;
    logic [7:0] acc_exp  = 8'h00;
    forever begin
      @(negedge clk);
      if (acc_pend) begin
        check("acc_writeback", acc1, acc_exp);
        acc_pend = 1'b0;
      end
      if (done1) begin
        if (sb_q.size() == 0) begin
          check("unexpected_done", done1, 1'b0);
        end else begin
          cur = sb_q.pop_front();
          check("drive_op", op1, cur.op);
          check("drive_bus", bus1, cur.bus);
          check("drive_oe", oe1, 1'b1);
          check("drive_breg", breg1, cur.breg);
          acc_pend = 1'b1;
          acc_exp  = cur.acc;
        end
      end
    end
  end

  task automatic push_exp(input logic [2:0] op, input logic [7:0] res, input logic [7:0] b);
    exp_t e;
    logic unary;
    unary = (op == 3'b010) || (op == 3'b011) || (op == 3'b100);
    if (!unary) breg_m = b;
    e.op = op; e.bus = res; e.acc = res; e.breg = breg_m;
    sb_q.push_back(e);
  endtask

  task automatic wait_done(input int cyc0, input int exp_lat, input string name);
    int cyc;
    cyc = cyc0;
    while (!done1 && cyc < 12) begin
      @(negedge clk);
      cyc++;
    end
    check(name, cyc, exp_lat);
  endtask

  task automatic run_vec(input vec_t v);
    push_exp(v.opc, v.res, v.b);
    @(negedge clk);
    start = 1'b1; opc = v.opc; bus_valid = 1'b1; opnd = v.a;
    @(negedge clk);
    start = 1'b0;
    check("busy_ld_a", busy1, 1'b1);
    @(negedge clk);
    opnd = v.b;
    wait_done(2, v.lat, "latency");
    bus_valid = 1'b0;
  endtask

  vec_t vecs[9];

  initial begin
    logic seen;

    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic seen;
    vecs[0] = '{3'b000, 8'h12, 8'h34, 8'h46, 4};
    vecs[1] = '{3'b011, 8'hFF, 8'h00, 8'h00, 3};
    vecs[2] = '{3'b001, 8'h05, 8'h07, 8'hFE, 4};
    vecs[3] = '{3'b010, 8'h00, 8'h00, 8'hFF, 3};
    vecs[4] = '{3'b100, 8'h5A, 8'h00, 8'hA5, 3};
    vecs[5] = '{3'b101, 8'hF0, 8'h3C, 8'h30, 4};
    vecs[6] = '{3'b110, 8'hF0, 8'h0F, 8'hFF, 4};
    vecs[7] = '{3'b111, 8'hAA, 8'hFF, 8'h55, 4};
    vecs[8] = '{3'b000, 8'hFF, 8'h01, 8'h00, 4};

    // Reset values
    #3;
    check("rst_acc", acc1, 8'h00);
    check("rst_breg", breg1, 8'h00);
    check("rst_op", op1, 3'b000);
    check("rst_oe", oe1, 1'b0);
    check("rst_busy", busy1, 1'b0);
    check("rst_done", done1, 1'b0);
    check("rst_err", err1, 1'b0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 9; i++) run_vec(vecs[i]);

    // START ignored in LD_B and DRIVE, accepted right after DONE
    push_exp(3'b000, 8'h03, 8'h02);
    @(negedge clk);
    start = 1'b1; opc = 3'b000; bus_valid = 1'b1; opnd = 8'h01;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    opnd = 8'h02; start = 1'b1; opc = 3'b111;
    @(negedge clk);
    start = 1'b0;
    check("op_held_exec", op1, 3'b000);
    @(negedge clk);
    wait_done(4, 4, "latency_ign");
    start = 1'b1; opc = 3'b111;
    @(negedge clk);
    check("start_in_drive_ignored", busy1, 1'b0);
    push_exp(3'b011, 8'h11, 8'h00);
    opc = 3'b011; opnd = 8'h10;
    @(negedge clk);
    start = 1'b0;
    check("start_after_done", busy1, 1'b1);
    @(negedge clk);
    wait_done(2, 3, "latency_b2b");
    bus_valid = 1'b0;

    // Timeout in LD_B
    @(negedge clk);
    start = 1'b1; opc = 3'b001; bus_valid = 1'b1; opnd = 8'h05;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    bus_valid = 1'b0;
    seen = 1'b0;
    for (int c = 2; c <= 16; c++) begin
      seen = seen | err1 | oe1 | done1 | !busy1;
      if (c < 16) @(negedge clk);
    end
    check("to_no_early_err", seen, 1'b0);
    @(negedge clk);
    check("to_err", err1, 1'b1);
    check("to_busy", busy1, 1'b1);
    check("to_oe", oe1, 1'b0);
    check("to_done", done1, 1'b0);
    @(negedge clk);
    check("to_err_pulse", err1, 1'b0);
    check("to_busy_after", busy1, 1'b0);
    check("to_acc", acc1, 8'h05);
    check("to_breg", breg1, breg_m);

    // Asynchronous reset during DRIVE
    @(negedge clk);
    start = 1'b1; opc = 3'b000; bus_valid = 1'b1; opnd = 8'h11;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    opnd = 8'h22;
    @(negedge clk);
    bus_valid = 1'b0;
    @(posedge clk);
    #1;
    check("ar_oe_before", oe1, 1'b1);
    #1 rst = 1'b1;
    #1;
    check("ar_oe", oe1, 1'b0);
    check("ar_done", done1, 1'b0);
    check("ar_busy", busy1, 1'b0);
    check("ar_acc", acc1, 8'h00);
    check("ar_breg", breg1, 8'h00);
    check("ar_op", op1, 3'b000);
    breg_m = 8'h00;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("ar_needs_start", busy1, 1'b0);
    check("ar_no_writeback", acc1, 8'h00);

    // No write-back, timeout disabled
    @(negedge clk);
    start2 = 1'b1; opc = 3'b111; bus_valid = 1'b1; opnd = 8'hF0;
    @(negedge clk);
    start2 = 1'b0;
    @(negedge clk);
    bus_valid = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      seen = seen | err2 | oe2;
    end
    check("nwb_no_timeout", seen, 1'b0);
    check("nwb_busy_wait", busy2, 1'b1);
    bus_valid = 1'b1; opnd = 8'h0F;
    @(negedge clk);
    check("nwb_exec", done2, 1'b0);
    @(negedge clk);
    bus_valid = 1'b0;
    check("nwb_done", done2, 1'b1);
    check("nwb_bus", bus2, 8'hFF);
    @(negedge clk);
    check("nwb_acc", acc2, 8'hF0);
    check("nwb_breg", breg2, 8'h0F);
    check("nwb_idle", busy2, 1'b0);
    check("dut1_idle", busy1, 1'b0);

    @(negedge clk);
    check("sb_drain", sb_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
